gshare_bpred: RTL and testbench

Parametrised gshare direction predictor for the fetch/execute pipeline. It is the successor to the fixed 12-bit predictor and differs in four ways: the history length and table depth are configurable, it initialises its pattern table after reset, and it can optionally keep speculative global history with repair on a miss. It sits between the fetch stage, which presents a PC and receives a direction plus a table index, and the execute stage, which returns the resolved outcome.

---
 rtl/gshare_bpred_if.sv | 37 +++
 rtl/gshare_bpred.sv | 154 +++++++++++++++
 tb/tb_gshare_bpred.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_bpred_if.sv
// Fetch/execute/debug signal bundle for gshare_bpred; the predictor takes the slave modport.
// Handshake: a lookup transfers on a rising edge where fetch_bpredictor_valid && bpredictor_ready && !soin_bpredictor_stall; its results appear after that edge and are meaningful while bpredictor_fetch_valid is high.
interface gshare_bpred_if #(
    parameter int HIST_BITS = 12
);
    logic                 fetch_bpredictor_valid;
    logic [31:0]          fetch_bpredictor_PC;
    logic                 soin_bpredictor_stall;
    logic                 bpredictor_ready;
    logic                 bpredictor_fetch_valid;
    logic                 bpredictor_fetch_p_dir;
    logic [HIST_BITS-1:0] bpredictor_fetch_bimodal;
    logic [HIST_BITS-1:0] bpredictor_fetch_ghr;
    logic                 execute_bpredictor_update;
    logic                 execute_bpredictor_dir;
    logic                 execute_bpredictor_miss;
    logic [HIST_BITS-1:0] execute_bpredictor_bimodal;
    logic [HIST_BITS-1:0] execute_bpredictor_ghr;
    logic [1:0]           soin_bpredictor_debug_sel;
    logic [31:0]          bpredictor_soin_debug;

    modport master (
        output fetch_bpredictor_valid, fetch_bpredictor_PC, soin_bpredictor_stall,
        output execute_bpredictor_update, execute_bpredictor_dir, execute_bpredictor_miss,
        output execute_bpredictor_bimodal, execute_bpredictor_ghr, soin_bpredictor_debug_sel,
        input  bpredictor_ready, bpredictor_fetch_valid, bpredictor_fetch_p_dir,
        input  bpredictor_fetch_bimodal, bpredictor_fetch_ghr, bpredictor_soin_debug
    );

    modport slave (
        input  fetch_bpredictor_valid, fetch_bpredictor_PC, soin_bpredictor_stall,
        input  execute_bpredictor_update, execute_bpredictor_dir, execute_bpredictor_miss,
        input  execute_bpredictor_bimodal, execute_bpredictor_ghr, soin_bpredictor_debug_sel,
        output bpredictor_ready, bpredictor_fetch_valid, bpredictor_fetch_p_dir,
        output bpredictor_fetch_bimodal, bpredictor_fetch_ghr, bpredictor_soin_debug
    );
endinterface

// File: rtl/gshare_bpred.sv
// gshare direction predictor: (PC ^ global history) indexes 2-bit counters swept to CTR_INIT after reset.
// Define GSHARE_SPEC_HIST_EN for speculative history (shift on prediction, repair on a miss).
module gshare_bpred #(
    parameter int         HIST_BITS = 12,
    parameter int         PC_LSB    = 2,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input logic           clk,
    input logic           reset,
    gshare_bpred_if.slave bp
);
    localparam int                   DEPTH      = 1 << HIST_BITS;
    localparam logic [HIST_BITS-1:0] LAST_ENTRY = {HIST_BITS{1'b1}};
    localparam logic [0:0]           ST_INIT    = 1'b0;
    localparam logic [0:0]           ST_RUN     = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [HIST_BITS-1:0] sweep_q, sweep_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic                 fvalid_q, fvalid_d;
    logic                 pdir_q, pdir_d;
    logic [HIST_BITS-1:0] bimodal_q, bimodal_d;
    logic [HIST_BITS-1:0] fghr_q, fghr_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [HIST_BITS-1:0] pend_idx_q, pend_idx_d;
    logic [1:0]           pend_ctr_q, pend_ctr_d;
    logic [31:0]          upd_cnt_q, upd_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;
    logic [1:0]           pht_q [DEPTH];

    logic                 ready;
    logic                 lookup_acc;
    logic                 upd;
    logic [HIST_BITS-1:0] lookup_idx;
    logic [1:0]           lookup_ctr;
    logic [1:0]           upd_old;
    logic [1:0]           upd_new;
    logic                 unused_bits;

    assign ready       = (state_q == ST_RUN);
    assign lookup_acc  = bp.fetch_bpredictor_valid & ready & ~bp.soin_bpredictor_stall;
    assign upd         = bp.execute_bpredictor_update & ready;
    assign lookup_idx  = bp.fetch_bpredictor_PC[PC_LSB +: HIST_BITS] ^ ghr_q;
    assign lookup_ctr  = pht_q[lookup_idx];
    assign unused_bits = ^{bp.fetch_bpredictor_PC, bp.execute_bpredictor_ghr};

    // The counter still waiting in the write stage is newer than the table copy.
    assign upd_old = (pend_valid_q && pend_idx_q == bp.execute_bpredictor_bimodal)
                     ? pend_ctr_q : pht_q[bp.execute_bpredictor_bimodal];

    always_comb begin
        upd_new = upd_old;
        if (bp.execute_bpredictor_dir) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else if (upd_old != 2'b00) begin
            upd_new = upd_old - 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        ghr_d        = ghr_q;
        fvalid_d     = fvalid_q;
        pdir_d       = pdir_q;
        bimodal_d    = bimodal_q;
        fghr_d       = fghr_q;
        pend_valid_d = upd;
        pend_idx_d   = bp.execute_bpredictor_bimodal;
        pend_ctr_d   = upd_new;
        upd_cnt_d    = upd_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_ENTRY) state_d = ST_RUN;
        end

        if (!bp.soin_bpredictor_stall) fvalid_d = lookup_acc;
        if (lookup_acc) begin
            pdir_d    = lookup_ctr[1];
            bimodal_d = lookup_idx;
            fghr_d    = ghr_q;
        end

        if (upd) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
            if (bp.execute_bpredictor_miss) miss_cnt_d = miss_cnt_q + 32'd1;
        end

`ifdef GSHARE_SPEC_HIST_EN
        // Repair from the returned checkpoint outranks this cycle's speculative shift.
        if (upd && bp.execute_bpredictor_miss)
            ghr_d = {bp.execute_bpredictor_ghr[HIST_BITS-2:0], bp.execute_bpredictor_dir};
        else if (lookup_acc)
            ghr_d = {ghr_q[HIST_BITS-2:0], lookup_ctr[1]};
`else
        if (upd) ghr_d = {ghr_q[HIST_BITS-2:0], bp.execute_bpredictor_dir};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            ghr_q        <= '0;
            fvalid_q     <= 1'b0;
            pdir_q       <= 1'b0;
            bimodal_q    <= '0;
            fghr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_ctr_q   <= 2'b00;
            upd_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            ghr_q        <= ghr_d;
            fvalid_q     <= fvalid_d;
            pdir_q       <= pdir_d;
            bimodal_q    <= bimodal_d;
            fghr_q       <= fghr_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            pend_ctr_q   <= pend_ctr_d;
            upd_cnt_q    <= upd_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Single write port: the init sweep owns it until RUN, then the update stage.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)
            pht_q[sweep_q] <= CTR_INIT;
        else if (pend_valid_q)
            pht_q[pend_idx_q] <= pend_ctr_q;
    end

    always_comb begin
        case (bp.soin_bpredictor_debug_sel)
            2'd0:    bp.bpredictor_soin_debug = 32'(ghr_q);
            2'd1:    bp.bpredictor_soin_debug = upd_cnt_q;
            2'd2:    bp.bpredictor_soin_debug = miss_cnt_q;
            default: bp.bpredictor_soin_debug = {ready, 15'b0, 16'(sweep_q)};
        endcase
    end

    assign bp.bpredictor_ready         = ready;
    assign bp.bpredictor_fetch_valid   = fvalid_q;
    assign bp.bpredictor_fetch_p_dir   = pdir_q;
    assign bp.bpredictor_fetch_bimodal = bimodal_q;
    assign bp.bpredictor_fetch_ghr     = fghr_q;
endmodule

// File: tb/tb_gshare_bpred.sv
// Bench for gshare_bpred at HIST_BITS=4 against a table model whose updates become visible two cycles late.
// Compile with or without GSHARE_SPEC_HIST_EN; the model follows the same macro.
module tb_gshare_bpred;
    localparam int HB  = 4;
    localparam int PCL = 2;
    localparam int W   = 1 + 2 * HB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gshare_bpred_if #(.HIST_BITS(HB)) bif ();
    gshare_bpred #(.HIST_BITS(HB), .PC_LSB(PCL), .CTR_INIT(2'b01)) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          tbl  [16];
    int          lag1 [16];
    int          lag2 [16];
    logic [HB-1:0] m_ghr;
    logic [31:0] m_upd, m_miss;
    logic        m_ready;
    logic        e_fvalid;
    logic [W-1:0] held;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic up,
                         input logic d, input logic ms, input logic [HB-1:0] ei,
                         input logic [HB-1:0] eg, input logic [1:0] ds);
        bif.fetch_bpredictor_valid     = v;
        bif.fetch_bpredictor_PC        = pc;
        bif.soin_bpredictor_stall      = st;
        bif.execute_bpredictor_update  = up;
        bif.execute_bpredictor_dir     = d;
        bif.execute_bpredictor_miss    = ms;
        bif.execute_bpredictor_bimodal = ei;
        bif.execute_bpredictor_ghr     = eg;
        bif.soin_bpredictor_debug_sel  = ds;
    endtask

    function automatic logic [31:0] dbg_exp(input logic [1:0] ds);
        case (ds)
            2'd0:    return {28'b0, m_ghr};
            2'd1:    return m_upd;
            default: return m_miss;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin tbl[i] = 1; lag1[i] = 1; lag2[i] = 1; end
        m_ghr = '0; m_upd = '0; m_miss = '0; m_ready = 1'b0; e_fvalid = 1'b0;
        held = '0; exp_q.delete();
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic st, input logic up,
                        input logic d, input logic ms, input logic [HB-1:0] ei,
                        input logic [HB-1:0] eg, input logic [1:0] ds);
        logic acc, updv, pd;
        logic [HB-1:0] idx;
        drive(v, pc, st, up, d, ms, ei, eg, ds);
        acc  = v && m_ready && !st;
        updv = up && m_ready;
        idx  = pc[PCL +: HB] ^ m_ghr;
        pd   = (lag2[idx] >= 2);
        if (!st) e_fvalid = acc;
        if (acc) exp_q.push_back({pd, idx, m_ghr});
`ifdef GSHARE_SPEC_HIST_EN
        if (updv && ms) m_ghr = {eg[HB-2:0], d};
        else if (acc)   m_ghr = {m_ghr[HB-2:0], pd};
`else
        if (updv) m_ghr = {m_ghr[HB-2:0], d};
`endif
        if (updv) begin
            tbl[ei] = d ? ((tbl[ei] == 3) ? 3 : tbl[ei] + 1) : ((tbl[ei] == 0) ? 0 : tbl[ei] - 1);
            m_upd = m_upd + 1;
            if (ms) m_miss = m_miss + 1;
        end
        lag2 = lag1;
        lag1 = tbl;
        @(posedge clk); #1;
        if (acc) held = exp_q.pop_front();
        check("fetch_valid", 32'(bif.bpredictor_fetch_valid), 32'(e_fvalid));
        if (e_fvalid) begin
            check("p_dir", 32'(bif.bpredictor_fetch_p_dir), 32'(held[W-1]));
            check("bimodal", 32'(bif.bpredictor_fetch_bimodal), 32'(held[2*HB-1:HB]));
            check("fetch_ghr", 32'(bif.bpredictor_fetch_ghr), 32'(held[HB-1:0]));
        end
        check("debug", bif.bpredictor_soin_debug, dbg_exp(ds));
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_ready", 32'(bif.bpredictor_ready), 0);
        check("rst_fvalid", 32'(bif.bpredictor_fetch_valid), 0);
        check("rst_pdir", 32'(bif.bpredictor_fetch_p_dir), 0);
        check("rst_bimodal", 32'(bif.bpredictor_fetch_bimodal), 0);
        check("rst_fghr", 32'(bif.bpredictor_fetch_ghr), 0);
        check("rst_ghr", bif.bpredictor_soin_debug, 0);
        bif.soin_bpredictor_debug_sel = 2'd1; #1;
        check("rst_updcnt", bif.bpredictor_soin_debug, 0);
        bif.soin_bpredictor_debug_sel = 2'd2; #1;
        check("rst_misscnt", bif.bpredictor_soin_debug, 0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sweep phase with random traffic that must be ignored.
    task automatic do_init();
        for (int k = 1; k <= 16; k++) begin
            drive($urandom_range(0, 1), $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), HB'($urandom), HB'($urandom), 2'd3);
            @(posedge clk); #1;
            check("init_ready", 32'(bif.bpredictor_ready), (k == 16) ? 1 : 0);
            check("init_fvalid", 32'(bif.bpredictor_fetch_valid), 0);
            if (k < 16) check("init_sweep", bif.bpredictor_soin_debug, 32'(k));
            else        check("ready_dbg", 32'(bif.bpredictor_soin_debug[31]), 1);
            @(negedge clk);
        end
        m_ready = 1'b1;
    endtask

    initial begin
        logic [HB-1:0] saved_ghr;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        do_reset(2);
        do_init();

        // Index from PC with empty history
        step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        check("bimodal_0x80", 32'(bif.bpredictor_fetch_bimodal), 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 32'(i << PCL), 0, 0, 0, 0, 0, 0, 0);
            check("weak_nt_pdir", 32'(bif.bpredictor_fetch_p_dir), 0);
        end

        // Two back-to-back increments at index 0, then a lookup two cycles later
        step(0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'(m_ghr) << PCL, 0, 0, 0, 0, 0, 0, 0);
        check("taken_after_2up", 32'(bif.bpredictor_fetch_p_dir), 1);

        // Four decrements saturate at 0; one increment leaves it not-taken
        repeat (4) step(0, 0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'(m_ghr) << PCL, 0, 0, 0, 0, 0, 0, 0);
        check("sat_low_pdir", 32'(bif.bpredictor_fetch_p_dir), 0);

        // Stall holds the previous result for three cycles
        step(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 32'h1c, 1, 0, 0, 0, 0, 0, 0);
        step(1, 32'h1c, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 HB'($urandom), HB'($urandom), 2'($urandom_range(0, 2)));

        // History behaviour: clear ghr, make index 0 strongly taken, three taken lookups, then a miss
        step(0, 0, 0, 1, 0, 1, 4'd5, 4'b0000, 0);
        repeat (3) step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        saved_ghr = m_ghr;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'(m_ghr) << PCL, 0, 0, 0, 0, 0, 0, 0);
            check("hist_taken", 32'(bif.bpredictor_fetch_p_dir), 1);
        end
`ifdef GSHARE_SPEC_HIST_EN
        check("spec_ghr_0111", bif.bpredictor_soin_debug, 32'h7);
        step(0, 0, 0, 1, 0, 1, 4'd9, 4'b0010, 0);
        check("spec_repair_0100", bif.bpredictor_soin_debug, 32'h4);
`else
        check("commit_ghr_hold", bif.bpredictor_soin_debug, 32'(saved_ghr));
        step(0, 0, 0, 1, 0, 1, 4'd9, 4'b0010, 0);
`endif

        // Reset in the middle of the sweep restarts it
        do_reset(2);
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd3);
            @(posedge clk); #1;
            if (k == 7) check("sweep_at_7", bif.bpredictor_soin_debug, 32'd7);
            @(negedge clk);
        end
        do_reset(1);
        bif.soin_bpredictor_debug_sel = 2'd3; #1;
        check("sweep_restart", bif.bpredictor_soin_debug, 0);
        do_init();

        // Six updates with two misses
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 1, $urandom_range(0, 1), (i == 1 || i == 4), HB'($urandom), HB'($urandom), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("upd_count_6", bif.bpredictor_soin_debug, 32'd6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2);
        check("miss_count_2", bif.bpredictor_soin_debug, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
